// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_hs
// Purpose  : Single-port data memory with valid/ready request/response
//            handshake, per-byte write strobes, range checking and an
//            optional zero-fill sweep after every reset.
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_ready/req_wen/req_addr/req_wdata/req_wstrb
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err
//            init_done  - zero-fill sweep finished, requests may be accepted
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int INIT_ZERO  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_done
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]    C_LAST  = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_init_done;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_wr;
  logic             w_rd;
  logic             w_sweep_we;
  logic             w_last;

  // Compare with one extra bit so DEPTH == 2**ADDR_WIDTH stays representable.
  assign w_in_range  = ({1'b0, req_addr} < C_DEPTH);
  assign w_idx       = req_addr[IDX_W-1:0];
  // Ready is gated by init_done so nothing is accepted during reset or sweep;
  // a held response blocks new requests unless it is consumed this cycle.
  assign w_req_ready = r_init_done && (!r_rsp_valid || rsp_ready);
  assign w_accept    = req_valid && w_req_ready;
  assign w_wr        = w_accept && req_wen && w_in_range;
  assign w_rd        = w_accept && !req_wen;
  assign w_sweep_we  = (r_state == ST_INIT);
  assign w_last      = (r_cnt == C_LAST);

  // Storage has no reset; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      mem[r_cnt[IDX_W-1:0]] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (req_wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (w_last) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase

      // A new read reloads the response register; otherwise a consumed
      // response retires and a stalled one is held unchanged.
      if (w_rd) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_in_range ? mem[w_idx] : '0;
        r_rsp_err   <= !w_in_range;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_hs
// Purpose  : Self-checking bench for data_mem_hs (DEPTH=12, ADDR_WIDTH=4,
//            INIT_ZERO=1) using directed scenarios and a randomized
//            cycle-level reference model of the memory and response slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_hs;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int SW    = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err, init_done;
  logic [DW-1:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  data_mem_hs #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_ZERO(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0;   req_wstrb = '0;
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return (a < DEPTH) ? ref_mem[a] : '0;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
    if (a < DEPTH)
      for (int b = 0; b < SW; b++)
        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output bit ok);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
      model_write(a, d, s);
    end
    idle();
  endtask

  // Issues one read with rsp_ready high; samples the response one cycle later.
  task automatic do_read(input logic [AW-1:0] a, output bit vld,
                         output logic [DW-1:0] d, output logic e, output bit ok);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = a;
    ok = 1'b0; vld = 1'b0; d = '0; e = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      vld = rsp_valid; d = rsp_rdata; e = rsp_err;
    end
    idle();
  endtask

  task automatic test_reset();
    idle(); rsp_ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, init_done, rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%b vld=%b err=%b done=%b data=%h want all 0",
               req_ready, rsp_valid, rsp_err, init_done, rsp_rdata);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      n_cmp++;
      if (init_done !== (i == DEPTH) || req_ready !== (i == DEPTH)) begin
        n_bad++;
        $display("FAIL sweep_cycle_%0d: got done=%b rdy=%b want %b", i,
                 init_done, req_ready, (i == DEPTH));
      end
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
  endtask

  task automatic test_sweep_zero();
    bit vld, ok; logic [DW-1:0] d; logic e;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), vld, d, e, ok);
      n_cmp++;
      if (!ok || vld !== 1'b1 || d !== '0 || e !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_zero_%0d: got ok=%b vld=%b data=%h err=%b want 1 1 0 0",
                 a, ok, vld, d, e);
      end
    end
  endtask

  task automatic test_strobe();
    bit vld, ok1, ok2, ok; logic [DW-1:0] d; logic e;
    do_write(4'd3, 32'hDEADBEEF, 4'b1111, ok1);
    do_write(4'd3, 32'h000000AA, 4'b0001, ok2);
    do_read(4'd3, vld, d, e, ok);
    n_cmp++;
    if (!(ok1 && ok2 && ok) || vld !== 1'b1 || d !== 32'hDEADBEAA || e !== 1'b0) begin
      n_bad++;
      $display("FAIL byte_strobe: got vld=%b data=%h err=%b want 1 deadbeaa 0", vld, d, e);
    end
    // wstrb=0 must leave the word untouched
    do_write(4'd3, 32'h12345678, 4'b0000, ok1);
    do_write(4'd4, 32'hCAFEF00D, 4'b1010, ok2);
    do_read(4'd3, vld, d, e, ok);
    n_cmp++;
    if (!(ok1 && ok) || d !== 32'hDEADBEAA) begin
      n_bad++;
      $display("FAIL strobe_zero: got %h want deadbeaa", d);
    end
    do_read(4'd4, vld, d, e, ok);
    n_cmp++;
    if (!(ok2 && ok) || d !== 32'hCA00F000) begin
      n_bad++;
      $display("FAIL strobe_mixed: got %h want ca00f000", d);
    end
  endtask

  task automatic test_stall();
    bit ok = 1'b0;
    logic [DW-1:0] exp3 = ref_read(4'd3);
    logic [DW-1:0] exp5;
    do_write(4'd5, 32'h0BADF00D, 4'b1111, ok);
    exp5 = ref_read(4'd5);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 4'd3;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_addr = 4'd5;  // next read waits while the first response is held
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== exp3 || rsp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got vld=%b data=%h err=%b rdy=%b want 1 %h 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, exp3);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release_ready: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp5) begin
      n_bad++;
      $display("FAIL stall_followup: got vld=%b data=%h want 1 %h", rsp_valid, rsp_rdata, exp5);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_retire: got vld=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit okw = 1'b1;
    for (int a = 0; a < 3; a++) begin
      do_write(AW'(a), $urandom, 4'b1111, ok);
      okw &= ok;
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 4'd0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    for (int a = 0; a < 3; a++) begin
      @(posedge clk); #1;
      if (a < 2) req_addr = AW'(a + 1);
      else idle();
      @(negedge clk);
      n_cmp++;
      if (!(ok && okw) || rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[a] ||
          (a < 2 && req_ready !== 1'b1)) begin
        n_bad++;
        $display("FAIL b2b_%0d: got vld=%b data=%h rdy=%b want 1 %h 1",
                 a, rsp_valid, rsp_rdata, req_ready, ref_mem[a]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: got vld=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_out_of_range();
    bit vld, ok, okw; logic [DW-1:0] d; logic e;
    do_write(4'd13, 32'h00000055, 4'b1111, okw);
    do_read(4'd13, vld, d, e, ok);
    n_cmp++;
    if (!(okw && ok) || vld !== 1'b1 || d !== '0 || e !== 1'b1) begin
      n_bad++;
      $display("FAIL oob_13: got vld=%b data=%h err=%b want 1 0 1", vld, d, e);
    end
    do_read(AW'(DEPTH), vld, d, e, ok);
    n_cmp++;
    if (!ok || vld !== 1'b1 || d !== '0 || e !== 1'b1) begin
      n_bad++;
      $display("FAIL oob_depth: got vld=%b data=%h err=%b want 1 0 1", vld, d, e);
    end
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), vld, d, e, ok);
      n_cmp++;
      if (!ok || d !== ref_mem[a] || e !== 1'b0) begin
        n_bad++;
        $display("FAIL oob_intact_%0d: got data=%h err=%b want %h 0", a, d, e, ref_mem[a]);
      end
    end
  endtask

  task automatic test_random();
    bit exp_valid = 1'b0, exp_ready, accept;
    logic [DW-1:0] exp_data = '0;
    logic exp_err = 1'b0;
    idle(); rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_wen   = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_wstrb = SW'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_ready = !exp_valid || rsp_ready;
      n_cmp++;
      if (req_ready !== exp_ready || rsp_valid !== exp_valid ||
          (exp_valid && (rsp_rdata !== exp_data || rsp_err !== exp_err))) begin
        n_bad++;
        $display("FAIL random_c%0d: got rdy=%b vld=%b data=%h err=%b want %b %b %h %b",
                 c, req_ready, rsp_valid, rsp_rdata, rsp_err,
                 exp_ready, exp_valid, exp_data, exp_err);
      end
      accept = req_valid && exp_ready;
      if (accept && !req_wen) begin
        exp_valid = 1'b1;
        exp_data  = ref_read(req_addr);
        exp_err   = !(req_addr < DEPTH);
      end else if (rsp_ready) begin
        exp_valid = 1'b0;
      end
      if (accept && req_wen) model_write(req_addr, req_wdata, req_wstrb);
      @(posedge clk); #1;
    end
    idle(); rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    bit vld, ok; logic [DW-1:0] d; logic e;
    do_write(4'd0, 32'h11111111, 4'b1111, ok);
    do_write(4'd11, 32'hBBBBBBBB, 4'b1111, ok);
    // Leave a response pending so reset has to clear it.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 4'd11;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1; idle();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, init_done, rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_rsp: got rdy=%b vld=%b err=%b done=%b data=%h want all 0",
               req_ready, rsp_valid, rsp_err, init_done, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, init_done, rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_sweep: got rdy=%b vld=%b err=%b done=%b want all 0",
               req_ready, rsp_valid, rsp_err, init_done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      n_cmp++;
      if (init_done !== (i == DEPTH) || req_ready !== (i == DEPTH)) begin
        n_bad++;
        $display("FAIL resweep_cycle_%0d: got done=%b rdy=%b want %b", i,
                 init_done, req_ready, (i == DEPTH));
      end
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), vld, d, e, ok);
      n_cmp++;
      if (!ok || vld !== 1'b1 || d !== '0 || e !== 1'b0) begin
        n_bad++;
        $display("FAIL resweep_zero_%0d: got vld=%b data=%h err=%b want 1 0 0", a, vld, d, e);
      end
    end
  endtask

  initial begin
    idle();
    rsp_ready = 1'b1;
    test_reset();
    test_sweep_zero();
    test_strobe();
    test_stall();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
